// File: rtl/octal_request_encoder.sv
// Octal request encoder: pending-request register with a registered grant/ACK handshake.
// Define OCTAL_ENC_ROUND_ROBIN_EN for round-robin grants; otherwise fixed priority (bit 7 highest).
module octal_request_encoder (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] A,
  input  logic       ACK,
  output logic [2:0] Y,
  output logic       VALID,
  output logic [7:0] PEND,
  output logic       DROP
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic [2:0] y_q, y_d;
  logic [2:0] last_q, last_d;
  logic       drop_q, drop_d;

  logic [7:0] clr;
  logic       accept;
  logic [2:0] sel;
  logic [2:0] idx;
  logic       found;

  assign accept = (state_q == GRANT) && ACK;
  assign clr    = accept ? (8'b1 << y_q) : '0;

  // Candidates are visited starting at LAST+1 with wrap; fixed priority keeps the
  // largest index seen, so its result does not depend on the starting point.
  always_comb begin
    sel   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = last_q + 3'(i) + 3'd1;
`ifdef OCTAL_ENC_ROUND_ROBIN_EN
      if (p_q[idx] && !found) begin
`else
      if (p_q[idx] && (!found || idx > sel)) begin
`endif
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    last_d  = last_q;
    p_d     = (p_q & ~clr) | (EN ? A : '0);
    drop_d  = EN && ((A & p_q & ~clr) != '0);
    case (state_q)
      IDLE: begin
        y_d = 3'd0;
        if (p_q != '0) begin
          y_d     = sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ACK) begin
          y_d     = 3'd0;
          last_d  = y_q;
          state_d = IDLE;
        end
      end
      default: begin
        y_d     = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      p_q     <= '0;
      y_q     <= 3'd0;
      last_q  <= 3'b111;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      y_q     <= y_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign Y     = y_q;
  assign VALID = (state_q == GRANT);
  assign PEND  = p_q;
  assign DROP  = drop_q;

endmodule

// File: tb/tb_octal_request_encoder.sv
// Scoreboard bench for octal_request_encoder: expected grant codes are queued by the
// stimulus thread and checked by a monitor at each accepted handshake.
module tb_octal_request_encoder;

  logic       CLK = 1'b0;
  logic       RST, EN, ACK;
  logic [7:0] A;
  logic [2:0] Y;
  logic       VALID, DROP;
  logic [7:0] PEND;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  first_code, second_code;

  octal_request_encoder dut (
    .CLK(CLK), .RST(RST), .EN(EN), .A(A), .ACK(ACK),
    .Y(Y), .VALID(VALID), .PEND(PEND), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [7:0] pend, input logic valid,
                           input logic [2:0] y, input logic drop);
    check({name, ".PEND"},  PEND,         pend);
    check({name, ".VALID"}, 8'(VALID),    8'(valid));
    check({name, ".Y"},     8'(Y),        8'(y));
    check({name, ".DROP"},  8'(DROP),     8'(drop));
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; A = 8'h00; ACK = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // Monitor: every accepted handshake must match the next queued code.
  initial begin
    forever begin
      @(negedge CLK);
      if (VALID && ACK && !RST) begin
        if (exp_q.size() == 0) begin
          check("grant.unexpected", 8'(Y), 8'hEE);
        end else begin
          check("grant.code", 8'(Y), 8'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk_state("reset", 8'h00, 1'b0, 3'd0, 1'b0);

    // single request on bit 5, held until ACK
    EN = 1'b1; A = 8'h20; tick();
    chk_state("req5.e1", 8'h20, 1'b0, 3'd0, 1'b0);
    EN = 1'b0; A = 8'h00; exp_q.push_back(3'd5); tick();
    chk_state("req5.e2", 8'h20, 1'b1, 3'd5, 1'b0);
    tick(); tick();
    chk_state("req5.hold", 8'h20, 1'b1, 3'd5, 1'b0);
    ACK = 1'b1; tick();
    chk_state("req5.ack", 8'h00, 1'b0, 3'd0, 1'b0);
    ACK = 1'b0;

    // EN low: A ignored
    EN = 1'b0; A = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_state("en0", 8'h00, 1'b0, 3'd0, 1'b0);
    end
    A = 8'h00;

    // two requests, ACK tied high, two rounds after reset
    do_reset();
`ifdef OCTAL_ENC_ROUND_ROBIN_EN
    first_code = 3'd0; second_code = 3'd7;
`else
    first_code = 3'd7; second_code = 3'd0;
`endif
    ACK = 1'b1;
    for (int r = 0; r < 2; r++) begin
      EN = 1'b1; A = 8'h81; tick();
      chk_state("pair.p", 8'h81, 1'b0, 3'd0, 1'b0);
      EN = 1'b0; A = 8'h00;
      exp_q.push_back(first_code);
      exp_q.push_back(second_code);
      tick();
      check("pair.v1", 8'(VALID), 8'h01);
      check("pair.y1", 8'(Y), 8'(first_code));
      tick();
      chk_state("pair.gap", 8'h81 & ~(8'h01 << first_code), 1'b0, 3'd0, 1'b0);
      tick();
      check("pair.v2", 8'(VALID), 8'h01);
      check("pair.y2", 8'(Y), 8'(second_code));
      tick();
      chk_state("pair.done", 8'h00, 1'b0, 3'd0, 1'b0);
    end
    ACK = 1'b0;

    // new request beats same-cycle clear; then a duplicate request drops
    EN = 1'b1; A = 8'h08; tick();
    EN = 1'b0; A = 8'h00; exp_q.push_back(3'd3); tick();
    chk_state("rw.g1", 8'h08, 1'b1, 3'd3, 1'b0);
    EN = 1'b1; A = 8'h08; ACK = 1'b1; exp_q.push_back(3'd3); tick();
    chk_state("rw.clr", 8'h08, 1'b0, 3'd0, 1'b0);
    EN = 1'b0; A = 8'h00; ACK = 1'b0; tick();
    chk_state("rw.g2", 8'h08, 1'b1, 3'd3, 1'b0);
    EN = 1'b1; A = 8'h08; tick();
    chk_state("rw.drop", 8'h08, 1'b1, 3'd3, 1'b1);
    EN = 1'b0; A = 8'h00; tick();
    chk_state("rw.drop_end", 8'h08, 1'b1, 3'd3, 1'b0);
    ACK = 1'b1; tick();
    chk_state("rw.ack", 8'h00, 1'b0, 3'd0, 1'b0);
    ACK = 1'b0;

    // reset during a grant, with activity on inputs
    EN = 1'b1; A = 8'h14; tick();
    EN = 1'b0; A = 8'h00; tick();
    chk_state("rst.pre", 8'h14, 1'b1, 3'd4, 1'b0);
    RST = 1'b1; EN = 1'b1; A = 8'hFF; tick();
    chk_state("rst.mid", 8'h00, 1'b0, 3'd0, 1'b0);
    RST = 1'b0; EN = 1'b0; A = 8'h00; tick();
    chk_state("rst.after", 8'h00, 1'b0, 3'd0, 1'b0);

    check("scoreboard.leftover", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
